// File: rtl/mant_align_seq_pkg.sv
// Shared constants for the mantissa alignment block: FSM encoding and default sizes.
// Combinational definitions only; no latency, no flow control.
// Imported by the interface, the step shifter and the top.
package mant_align_pkg;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_STEP  = 4;
endpackage

// File: rtl/mant_align_seq_if.sv
// Request/result bundle for mant_align_seq: valid/ready request in, valid/ready result out.
// Pure wiring; no latency.
// Backpressure is carried by in_ready/out_ready.
interface mant_align_seq_if
    import mant_align_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [31:0]      sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             sticky;
    logic             busy;

    modport master (
        output in_valid, a, sel, out_ready,
        input  in_ready, out_valid, y, sticky, busy
    );

    modport slave (
        input  in_valid, a, sel, out_ready,
        output in_ready, out_valid, y, sticky, busy
    );
endinterface

// File: rtl/mant_step_shifter.sv
// One alignment step: right-shift by 0..STEP and OR the discarded bits into a sticky bit.
// Latency 0 (combinational).
// No flow control.
module mant_step_shifter
    import mant_align_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    localparam int AW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] vec_shifted,
    output logic             sticky_bit
);
    logic [WIDTH-1:0] lost_mask;

    always_comb begin
        lost_mask   = ~({WIDTH{1'b1}} << amt);
        vec_shifted = vec >> amt;
        sticky_bit  = |(vec & lost_mask);
    end
endmodule

// File: rtl/mant_align_seq.sv
// Sequential mantissa right-aligner: shifts {1,frac} by sel at most STEP bits per cycle, tracks sticky.
// Latency 1 + ceil(sel/STEP) cycles for 0 <= sel < WIDTH; 1 cycle for negative or oversize sel.
// Accepts only in IDLE; result held in DONE until out_ready, no same-cycle re-accept.
module mant_align_seq
    import mant_align_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic               clk,
    input  logic               rst,
    mant_align_seq_if.slave    io
);
    localparam int AW = $clog2(STEP + 1);

    logic [1:0]       state;
    logic [31:0]      rem;
    logic [WIDTH-1:0] y_q;
    logic             sticky_q;

    logic [WIDTH-1:0] m_load;
    logic             unused_hidden;
    logic             sel_neg;
    logic             sel_big;
    logic [AW-1:0]    step_amt;
    logic [WIDTH-1:0] step_y;
    logic             step_sticky;

    // The operand's top bit is replaced by the implicit hidden one.
    assign m_load        = {1'b1, io.a[WIDTH-2:0]};
    assign unused_hidden = io.a[WIDTH-1];

    assign sel_neg = $signed(io.sel) < 0;
    assign sel_big = $signed(io.sel) >= $signed(32'(WIDTH));

    // rem never exceeds WIDTH-1 while shifting, so the narrow slice is exact when rem < STEP.
    assign step_amt = (rem < 32'(STEP)) ? rem[AW-1:0] : AW'(STEP);

    mant_step_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .vec         (y_q),
        .amt         (step_amt),
        .vec_shifted (step_y),
        .sticky_bit  (step_sticky)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            y_q      <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        y_q      <= m_load;
                        rem      <= io.sel;
                        sticky_q <= 1'b0;
                        if (sel_neg || io.sel == 32'd0) begin
                            state <= DONE;
                        end else if (sel_big) begin
                            y_q      <= '0;
                            sticky_q <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    y_q      <= step_y;
                    sticky_q <= sticky_q | step_sticky;
                    rem      <= rem - 32'(step_amt);
                    if (rem == 32'(step_amt)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.busy      = (state != IDLE);
    assign io.y         = y_q;
    assign io.sticky    = sticky_q;
endmodule

// File: tb/tb_mant_align_seq.sv
// Directed bench for mant_align_seq: results, latency, backpressure, ignored requests, mid-shift reset.
module tb_mant_align_seq;
    import mant_align_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   lat;
    logic seen;

    always #5 clk = ~clk;

    mant_align_seq_if #(.WIDTH(24)) bus ();

    mant_align_seq #(.WIDTH(24), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge in IDLE; returns cycles from accept edge to out_valid.
    // With noise=1 a different request is held on the inputs while the block works.
    task automatic do_req(input logic [23:0] av, input logic [31:0] sv, input logic noise,
                          output int l);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.sel      = sv;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = noise;
        bus.a        = ~av;
        bus.sel      = 32'd0;
        l = 1;
        while (!bus.out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic consume(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_y",         32'(bus.y),         32'd0);
        chk("rst_sticky",    32'(bus.sticky),    32'd0);

        do_req(24'h000000, 32'd0, 1'b0, lat);
        chk("sel0_lat", lat, 1);
        chk("sel0_y", 32'(bus.y), 32'h800000);
        chk("sel0_st", 32'(bus.sticky), 32'd0);
        consume("sel0");
        chk("sel0_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_hold_y", 32'(bus.y), 32'h800000);

        // Result held under backpressure while a foreign request is offered.
        do_req(24'h7FFFFF, 32'd5, 1'b0, lat);
        chk("sel5_lat", lat, 3);
        chk("sel5_y", 32'(bus.y), 32'h07FFFF);
        chk("sel5_st", 32'(bus.sticky), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = 24'h000000;
        bus.sel      = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_y",         32'(bus.y),         32'h07FFFF);
            chk("bp_st",        32'(bus.sticky),    32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        consume("sel5");

        do_req(24'h123456, 32'hFFFFFFFF, 1'b0, lat);
        chk("neg1_lat", lat, 1);
        chk("neg1_y", 32'(bus.y), 32'h923456);
        chk("neg1_st", 32'(bus.sticky), 32'd0);
        consume("neg1");

        do_req(24'h0ABCDE, 32'h80000000, 1'b0, lat);
        chk("negmin_lat", lat, 1);
        chk("negmin_y", 32'(bus.y), 32'h8ABCDE);
        chk("negmin_st", 32'(bus.sticky), 32'd0);
        consume("negmin");

        do_req(24'h5A5A5A, 32'd24, 1'b0, lat);
        chk("sel24_lat", lat, 1);
        chk("sel24_y", 32'(bus.y), 32'd0);
        chk("sel24_st", 32'(bus.sticky), 32'd1);
        consume("sel24");

        do_req(24'h000000, 32'h7FFFFFFF, 1'b0, lat);
        chk("selmax_lat", lat, 1);
        chk("selmax_y", 32'(bus.y), 32'd0);
        chk("selmax_st", 32'(bus.sticky), 32'd1);
        consume("selmax");

        // Requests offered during SHIFT and DONE must be ignored.
        do_req(24'h000000, 32'd23, 1'b1, lat);
        chk("sel23_lat", lat, 7);
        chk("sel23_y", 32'(bus.y), 32'h000001);
        chk("sel23_st", 32'(bus.sticky), 32'd0);
        consume("sel23");

        do_req(24'h000001, 32'd1, 1'b0, lat);
        chk("sel1_lat", lat, 2);
        chk("sel1_y", 32'(bus.y), 32'h400000);
        chk("sel1_st", 32'(bus.sticky), 32'd1);
        consume("sel1");

        do_req(24'h00000F, 32'd4, 1'b0, lat);
        chk("sel4_lat", lat, 2);
        chk("sel4_y", 32'(bus.y), 32'h080000);
        chk("sel4_st", 32'(bus.sticky), 32'd1);
        consume("sel4");

        do_req(24'h0000FF, 32'd8, 1'b0, lat);
        chk("sel8_lat", lat, 3);
        chk("sel8_y", 32'(bus.y), 32'h008000);
        chk("sel8_st", 32'(bus.sticky), 32'd1);
        consume("sel8");

        // Abort an in-flight request with a one-cycle reset.
        bus.in_valid = 1'b1;
        bus.a        = 24'h000000;
        bus.sel      = 32'd20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",      32'(bus.busy),      32'd0);
        chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_y",         32'(bus.y),         32'd0);
        chk("abort_st",        32'(bus.sticky),    32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mant_align_seq.md
MANT_ALIGN_SEQ -- requirements
Module: mant_align_seq

Interface
REQ-001 Parameters SHALL be: WIDTH, 24, mantissa width including hidden bit; STEP, 4, maximum right-shift bits per cycle.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block accepts a request.
- a  in  WIDTH  operand; only a[WIDTH-2:0] (fraction) is used.
- sel  in  32  signed right-shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  aligned mantissa.
- sticky  out  1  OR of all bits shifted out.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE.
- A request is accepted on a clk edge with in_valid=1 and in_ready=1.
- in_valid SHALL be ignored in SHIFT and DONE.
REQ-005 On accept, the working register SHALL load m = {1'b1, a[WIDTH-2:0]}, the remaining count SHALL load sel, and sticky SHALL clear.
REQ-006 If sel < 0 (signed, including 32'hFFFFFFFF), the block SHALL NOT shift: next state DONE, y = m, sticky = 0.
REQ-007 If sel = 0, next state SHALL be DONE with y = m and sticky = 0.
REQ-008 If sel >= WIDTH (signed compare over all 32 bits), next state SHALL be DONE with y = 0 and sticky = 1.
REQ-009 If 1 <= sel <= WIDTH-1, next state SHALL be SHIFT.
REQ-010 Each SHIFT cycle SHALL:
- shift m right by s = min(STEP, remaining);
- OR the s discarded bits into sticky;
- decrement remaining by s;
- go to DONE when remaining reaches 0.
REQ-011 Latency SHALL be 1 + ceil(sel/STEP) cycles from the accept edge to out_valid for 0 <= sel <= WIDTH-1, and 1 cycle for the cases in REQ-006 and REQ-008.
REQ-012 In DONE:
- out_valid SHALL be 1.
- y and sticky SHALL be registered and held stable until out_ready=1.
- On out_valid & out_ready the next state SHALL be IDLE.
- There is no same-cycle bypass to a new accept.
REQ-013 y and sticky SHALL keep their last values in IDLE. out_valid SHALL be 0 outside DONE.
REQ-014 No intermediate or output vector SHALL have zero or negative width for any legal WIDTH >= 2, STEP >= 1.

Reset
REQ-015 When rst=1 at a clk edge, the block SHALL enter IDLE and set:
- y = 0, sticky = 0, out_valid = 0, busy = 0;
- remaining count = 0;
- in_ready = 1 in the following cycle.
REQ-016 Reset SHALL take priority over accept and over completion handshakes.
REQ-017 Reset in SHIFT or DONE SHALL abort and discard the in-flight request without asserting out_valid.

Structure
REQ-018 A shared package mant_align_pkg SHALL hold:
- the state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
- the default WIDTH and STEP constants.
REQ-019 The per-cycle shift-and-sticky logic SHALL be one combinational sub-module, mant_step_shifter.
- Inputs: vector, shift amount 0..STEP.
- Outputs: shifted vector, sticky bit.

Verification
REQ-020 a=24'h000000, sel=0 -> y=24'h800000, sticky=0, out_valid 1 cycle after accept.
REQ-021 a=24'h7FFFFF, sel=5 -> y=24'h07FFFF, sticky=1, out_valid 3 cycles after accept.
REQ-022 a=24'h123456, sel=32'hFFFFFFFF -> y=24'h923456, sticky=0, latency 1.
REQ-023 sel=24 with any a -> y=0, sticky=1, latency 1. a=0, sel=23 -> y=24'h000001, sticky=0, latency 7.
REQ-024 Backpressure and ignored requests:
- Hold out_ready=0 for 5 cycles in DONE -> y and sticky stable, in_ready=0.
- in_valid pulses during SHIFT and DONE are not accepted.
REQ-025 Assert rst for one cycle during SHIFT (a=0, sel=20) -> next cycle: IDLE, out_valid=0, y=0, sticky=0, in_ready=1; no result is ever emitted for that request.
